// File: rtl/mfp_ahb_master_arbiter.sv
// N-master AHB-Lite arbiter in front of mfp_ahb. Ownership moves only when the
// current owner is IDLE, unlocked and the slave is ready; other requesters stall.

module mfp_ahb_arb_lane (
  input  logic [1:0] htrans_i,
  input  logic       own_i,
  input  logic       s_hready_i,
  output logic       req_o,
  output logic       hready_o
);
  assign req_o    = htrans_i[1];
  // A requesting non-owner is held off so its address/control stay stable.
  assign hready_o = own_i ? s_hready_i : ~htrans_i[1];
endmodule

module mfp_ahb_master_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int ARB_MODE       = 0,
  parameter int DEFAULT_MASTER = 0,
  parameter int IDX_W          = (N_MASTERS < 2) ? 1 : $clog2(N_MASTERS)
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [N_MASTERS*32-1:0] M_HADDR,
  input  logic [N_MASTERS*3-1:0]  M_HBURST,
  input  logic [N_MASTERS-1:0]    M_HMASTLOCK,
  input  logic [N_MASTERS*4-1:0]  M_HPROT,
  input  logic [N_MASTERS*3-1:0]  M_HSIZE,
  input  logic [N_MASTERS*2-1:0]  M_HTRANS,
  input  logic [N_MASTERS*32-1:0] M_HWDATA,
  input  logic [N_MASTERS-1:0]    M_HWRITE,
  output logic [N_MASTERS-1:0]    M_HREADY,
  output logic [31:0]             HRDATA,
  output logic                    HRESP,
  output logic [31:0]             S_HADDR,
  output logic [2:0]              S_HBURST,
  output logic                    S_HMASTLOCK,
  output logic [3:0]              S_HPROT,
  output logic [2:0]              S_HSIZE,
  output logic [1:0]              S_HTRANS,
  output logic [31:0]             S_HWDATA,
  output logic                    S_HWRITE,
  input  logic [31:0]             S_HRDATA,
  input  logic                    S_HREADY,
  input  logic                    S_HRESP,
  input  logic                    OVERRIDE_EN,
  input  logic [IDX_W-1:0]        OVERRIDE_SEL,
  output logic [N_MASTERS-1:0]    GRANT,
  output logic [IDX_W-1:0]        OWNER_IDX
);
  localparam int               IW1     = IDX_W + 1;
  localparam logic [IW1-1:0]   NM      = IW1'(N_MASTERS);
  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_MASTER);

  logic [IDX_W-1:0] owner_q, owner_d, downer_q, rr_q, rr_d, arb_idx;
  logic [N_MASTERS-1:0] req, own_oh;
  logic [N_MASTERS-1:0][31:0] haddr_a, hwdata_a;
  logic [N_MASTERS-1:0][2:0]  hburst_a, hsize_a;
  logic [N_MASTERS-1:0][3:0]  hprot_a;
  logic [N_MASTERS-1:0][1:0]  htrans_a;
  logic rearb, ovr_ok;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
    assign haddr_a[i]  = M_HADDR[32*i +: 32];
    assign hwdata_a[i] = M_HWDATA[32*i +: 32];
    assign hburst_a[i] = M_HBURST[3*i +: 3];
    assign hsize_a[i]  = M_HSIZE[3*i +: 3];
    assign hprot_a[i]  = M_HPROT[4*i +: 4];
    assign htrans_a[i] = M_HTRANS[2*i +: 2];
    assign own_oh[i]   = (owner_q == IDX_W'(i));
    mfp_ahb_arb_lane u_lane (
      .htrans_i  (htrans_a[i]),
      .own_i     (own_oh[i]),
      .s_hready_i(S_HREADY),
      .req_o     (req[i]),
      .hready_o  (M_HREADY[i])
    );
  end

  assign S_HADDR     = haddr_a[owner_q];
  assign S_HBURST    = hburst_a[owner_q];
  assign S_HMASTLOCK = M_HMASTLOCK[owner_q];
  assign S_HPROT     = hprot_a[owner_q];
  assign S_HSIZE     = hsize_a[owner_q];
  assign S_HTRANS    = htrans_a[owner_q];
  assign S_HWRITE    = M_HWRITE[owner_q];
  assign S_HWDATA    = hwdata_a[downer_q];
  assign HRDATA      = S_HRDATA;
  assign HRESP       = S_HRESP;
  assign GRANT       = own_oh;
  assign OWNER_IDX   = owner_q;

  assign rearb  = S_HREADY && (htrans_a[owner_q] == 2'b00) && !M_HMASTLOCK[owner_q];
  assign ovr_ok = OVERRIDE_EN && ({1'b0, OVERRIDE_SEL} < NM);

  always_comb begin
    logic [IW1-1:0] cand;
    logic           found;
    arb_idx = owner_q;
    cand    = '0;
    found   = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = N_MASTERS-1; i >= 0; i--)
        if (req[i]) arb_idx = IDX_W'(i);
    end else begin
      // Scan rr_q+1 upward with wrap; rr_q itself is the last candidate.
      for (int k = 1; k <= N_MASTERS; k++) begin
        cand = {1'b0, rr_q} + IW1'(k);
        if (cand >= NM) cand = cand - NM;
        if (!found && req[cand[IDX_W-1:0]]) begin
          arb_idx = cand[IDX_W-1:0];
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    owner_d = owner_q;
    rr_d    = rr_q;
    if (rearb) begin
      if (ovr_ok)    owner_d = OVERRIDE_SEL;
      else if (|req) owner_d = arb_idx;
      if (owner_d != owner_q) rr_d = owner_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q  <= DEF_IDX;
      downer_q <= DEF_IDX;
      rr_q     <= DEF_IDX;
    end else begin
      owner_q <= owner_d;
      rr_q    <= rr_d;
      if (S_HREADY) downer_q <= owner_q;
    end
  end
endmodule

// File: tb/tb_mfp_ahb_master_arbiter.sv
// Randomized + directed bench: a 3-master fixed-priority and a 4-master
// round-robin arbiter share stimulus and are checked against a behavioural model.
module tb_mfp_ahb_master_arbiter;
  localparam logic [1:0] IDLE = 2'b00, NS = 2'b10, SQ = 2'b11;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic [127:0] m_haddr, m_hwdata;
  logic [11:0]  m_hburst, m_hsize;
  logic [15:0]  m_hprot;
  logic [7:0]   m_htrans;
  logic [3:0]   m_lock, m_hwrite;
  logic [31:0]  s_hrdata;
  logic         s_hready, s_hresp, ovr_en;
  logic [1:0]   ovr_sel;

  logic [2:0]  a_mrdy, a_grant, a_hburst, a_hsize;
  logic [31:0] a_hrdata, a_haddr, a_hwdata;
  logic        a_hresp, a_lock, a_hwrite;
  logic [3:0]  a_hprot;
  logic [1:0]  a_htrans, a_oidx;
  logic [3:0]  b_mrdy, b_grant, b_hprot;
  logic [31:0] b_hrdata, b_haddr, b_hwdata;
  logic        b_hresp, b_lock, b_hwrite;
  logic [2:0]  b_hburst, b_hsize;
  logic [1:0]  b_htrans, b_oidx;
  logic [45:0] a_ctl, b_ctl;
  assign a_ctl = {a_haddr, a_hburst, a_lock, a_hprot, a_hsize, a_htrans, a_hwrite};
  assign b_ctl = {b_haddr, b_hburst, b_lock, b_hprot, b_hsize, b_htrans, b_hwrite};

  mfp_ahb_master_arbiter #(.N_MASTERS(3), .ARB_MODE(0), .DEFAULT_MASTER(0)) u_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M_HADDR(m_haddr[95:0]), .M_HBURST(m_hburst[8:0]), .M_HMASTLOCK(m_lock[2:0]),
    .M_HPROT(m_hprot[11:0]), .M_HSIZE(m_hsize[8:0]), .M_HTRANS(m_htrans[5:0]),
    .M_HWDATA(m_hwdata[95:0]), .M_HWRITE(m_hwrite[2:0]), .M_HREADY(a_mrdy),
    .HRDATA(a_hrdata), .HRESP(a_hresp),
    .S_HADDR(a_haddr), .S_HBURST(a_hburst), .S_HMASTLOCK(a_lock), .S_HPROT(a_hprot),
    .S_HSIZE(a_hsize), .S_HTRANS(a_htrans), .S_HWDATA(a_hwdata), .S_HWRITE(a_hwrite),
    .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .S_HRESP(s_hresp),
    .OVERRIDE_EN(ovr_en), .OVERRIDE_SEL(ovr_sel), .GRANT(a_grant), .OWNER_IDX(a_oidx));

  mfp_ahb_master_arbiter #(.N_MASTERS(4), .ARB_MODE(1), .DEFAULT_MASTER(0)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M_HADDR(m_haddr), .M_HBURST(m_hburst), .M_HMASTLOCK(m_lock),
    .M_HPROT(m_hprot), .M_HSIZE(m_hsize), .M_HTRANS(m_htrans),
    .M_HWDATA(m_hwdata), .M_HWRITE(m_hwrite), .M_HREADY(b_mrdy),
    .HRDATA(b_hrdata), .HRESP(b_hresp),
    .S_HADDR(b_haddr), .S_HBURST(b_hburst), .S_HMASTLOCK(b_lock), .S_HPROT(b_hprot),
    .S_HSIZE(b_hsize), .S_HTRANS(b_htrans), .S_HWDATA(b_hwdata), .S_HWRITE(b_hwrite),
    .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .S_HRESP(s_hresp),
    .OVERRIDE_EN(ovr_en), .OVERRIDE_SEL(ovr_sel), .GRANT(b_grant), .OWNER_IDX(b_oidx));

  int total = 0, bad = 0;
  int own[2], dow[2], rrp[2];
  int seq_rr[6] = '{0, 1, 2, 3, 0, 1};
  int seq_fp[5] = '{0, 1, 0, 1, 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic bit rq(int i);
    return m_htrans[2*i+1];
  endfunction

  // Who should own the bus after a rearbitration point, from the ownership rules.
  function automatic int pick(int d);
    int n, best, j;
    n = d ? 4 : 3;
    best = -1;
    if (ovr_en && int'(ovr_sel) < n) return int'(ovr_sel);
    for (int k = 0; k < n; k++) begin
      j = d ? (rrp[d] + 1 + k) % n : k;
      if (best < 0 && rq(j)) best = j;
    end
    return (best < 0) ? own[d] : best;
  endfunction

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      int n, o;
      logic [45:0] ce;
      logic [3:0]  ge, re;
      n = d ? 4 : 3;
      o = own[d];
      ce = {m_haddr[o*32 +: 32], m_hburst[o*3 +: 3], m_lock[o], m_hprot[o*4 +: 4],
            m_hsize[o*3 +: 3], m_htrans[o*2 +: 2], m_hwrite[o]};
      ge = '0;
      re = '0;
      for (int i = 0; i < n; i++) begin
        ge[i] = (i == o);
        re[i] = (i == o) ? s_hready : !rq(i);
      end
      if (d == 0) begin
        chk("A.ctl", 64'(a_ctl), 64'(ce));
        chk("A.wdata", 64'(a_hwdata), 64'(m_hwdata[dow[0]*32 +: 32]));
        chk("A.grant", 64'(a_grant), 64'(ge[2:0]));
        chk("A.owner", 64'(a_oidx), 64'(o));
        chk("A.hready", 64'(a_mrdy), 64'(re[2:0]));
        chk("A.resp", 64'({a_hresp, a_hrdata}), 64'({s_hresp, s_hrdata}));
      end else begin
        chk("B.ctl", 64'(b_ctl), 64'(ce));
        chk("B.wdata", 64'(b_hwdata), 64'(m_hwdata[dow[1]*32 +: 32]));
        chk("B.grant", 64'(b_grant), 64'(ge));
        chk("B.owner", 64'(b_oidx), 64'(o));
        chk("B.hready", 64'(b_mrdy), 64'(re));
        chk("B.resp", 64'({b_hresp, b_hrdata}), 64'({s_hresp, s_hrdata}));
      end
    end
  endtask

  task automatic step_model();
    for (int d = 0; d < 2; d++) begin
      int o, nx;
      o = own[d];
      if (s_hready) begin
        dow[d] = o;
        if (m_htrans[2*o +: 2] == IDLE && !m_lock[o]) begin
          nx = pick(d);
          if (nx != o) rrp[d] = nx;
          own[d] = nx;
        end
      end
    end
  endtask

  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic adv();
    step_model();
    @(negedge HCLK);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    #1;
    chk("rst.grantA", 64'(a_grant), 64'(3'b001));
    chk("rst.grantB", 64'(b_grant), 64'(4'b0001));
    chk("rst.ownerA", 64'(a_oidx), 64'(0));
    chk("rst.haddrA", 64'(a_haddr), 64'(m_haddr[31:0]));
    for (int d = 0; d < 2; d++) begin own[d] = 0; dow[d] = 0; rrp[d] = 0; end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic drv(input int i, input logic [1:0] tr, input logic [31:0] ad, input logic [31:0] wd);
    m_htrans[2*i +: 2] = tr;
    m_haddr[32*i +: 32] = ad;
    m_hwdata[32*i +: 32] = wd;
  endtask

  task automatic rand_in();
    for (int i = 0; i < 4; i++) begin
      int r;
      r = $urandom_range(0, 9);
      m_htrans[2*i +: 2] = (r < 4) ? IDLE : (r < 5) ? 2'b01 : (r < 8) ? NS : SQ;
      m_lock[i] = ($urandom_range(0, 7) == 0);
      m_hwrite[i] = 1'($urandom);
      m_haddr[32*i +: 32] = $urandom;
      m_hwdata[32*i +: 32] = $urandom;
      m_hburst[3*i +: 3] = 3'($urandom);
      m_hsize[3*i +: 3] = 3'($urandom);
      m_hprot[4*i +: 4] = 4'($urandom);
    end
    s_hready = ($urandom_range(0, 3) != 0);
    s_hresp  = ($urandom_range(0, 7) == 0);
    s_hrdata = $urandom;
    ovr_en   = ($urandom_range(0, 5) == 0);
    ovr_sel  = 2'($urandom);
  endtask

  initial begin
    rand_in();
    m_htrans = '0; m_lock = '0; ovr_en = 1'b0; ovr_sel = '0; s_hready = 1'b1; s_hresp = 1'b0;
    do_reset();

    // Stalled requester is granted one cycle after the owner idles; data one later.
    drv(0, NS, 32'h100, 32'h0); drv(1, NS, 32'h8000_0000, 32'h0);
    settle(); chk("lat.m1_stall", 64'(a_mrdy[1]), 64'(0)); chk("lat.grant0", 64'(a_grant), 64'(3'b001)); adv();
    drv(0, NS, 32'h104, 32'hA0);
    settle(); chk("lat.m1_stall2", 64'(a_mrdy[1]), 64'(0)); adv();
    drv(0, IDLE, 32'h0, 32'hA1);
    settle(); chk("lat.grant_t", 64'(a_grant), 64'(3'b001)); adv();
    drv(0, IDLE, 32'h0, 32'h0);
    settle(); chk("lat.grant_t1", 64'(a_grant), 64'(3'b010)); chk("lat.haddr_t1", 64'(a_haddr), 64'(32'h8000_0000)); adv();
    drv(1, IDLE, 32'h0, 32'hD1);
    settle(); chk("lat.wdata_t2", 64'(a_hwdata), 64'(32'hD1)); adv();

    // Wait states and lock both hold ownership.
    drv(0, NS, 32'h200, 32'h0); s_hready = 1'b0;
    repeat (3) begin settle(); chk("ws.hold", 64'(a_oidx), 64'(1)); adv(); end
    s_hready = 1'b1;
    settle(); chk("ws.ready_cycle", 64'(a_oidx), 64'(1)); adv();
    settle(); chk("ws.switch", 64'(a_oidx), 64'(0)); adv();
    drv(0, IDLE, 32'h0, 32'h0); m_lock[0] = 1'b1; drv(1, NS, 32'h300, 32'h0);
    repeat (3) begin settle(); chk("lock.hold", 64'(a_oidx), 64'(0)); chk("lock.m1_stall", 64'(a_mrdy[1]), 64'(0)); adv(); end
    m_lock[0] = 1'b0;
    settle(); adv();
    settle(); chk("lock.release", 64'(a_oidx), 64'(1)); adv();

    // Round-robin order with all masters requesting.
    m_htrans = '0; do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) drv(i, NS, 32'(32'h1000 * i), 32'(i));
      settle(); chk("rr.order", 64'(b_oidx), 64'(seq_rr[k])); adv();
      drv(seq_rr[k], IDLE, 32'h0, 32'h0);
      settle(); adv();
    end

    // Fixed priority: master0 wins every arbitration it takes part in.
    m_htrans = '0; do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) drv(i, NS, 32'(32'h2000 * i), 32'(i));
      settle(); chk("fp.order", 64'(a_oidx), 64'(seq_fp[k])); adv();
      drv(seq_fp[k], IDLE, 32'h0, 32'h0);
      settle(); adv();
    end

    // Override during an INCR4 burst.
    m_htrans = '0; do_reset();
    ovr_en = 1'b1; ovr_sel = 2'd1; m_hburst[2:0] = 3'b011;
    drv(1, NS, 32'h8000_0000, 32'h0);
    for (int j = 0; j < 4; j++) begin
      drv(0, (j == 0) ? NS : SQ, 32'(32'h400 + 4 * j), 32'h0);
      settle(); chk("ovr.burst_own", 64'(a_oidx), 64'(0)); chk("ovr.m1_stall", 64'(a_mrdy[1]), 64'(0)); adv();
    end
    drv(0, IDLE, 32'h0, 32'h0);
    settle(); chk("ovr.idle_own", 64'(a_oidx), 64'(0)); adv();
    drv(0, NS, 32'h500, 32'h0);
    settle(); chk("ovr.granted", 64'(a_oidx), 64'(1)); chk("ovr.m0_stall", 64'(a_mrdy[0]), 64'(0)); adv();
    drv(1, IDLE, 32'h0, 32'h0);
    repeat (2) begin settle(); chk("ovr.keep", 64'(a_oidx), 64'(1)); chk("ovr.m0_stall2", 64'(a_mrdy[0]), 64'(0)); adv(); end
    ovr_en = 1'b0;
    settle(); adv();
    settle(); chk("ovr.release", 64'(a_oidx), 64'(0)); adv();

    // Out-of-range override on the 3-master arbiter is ignored; in range on the 4-master one.
    m_htrans = '0; ovr_en = 1'b1; ovr_sel = 2'd3;
    drv(2, NS, 32'h600, 32'h0);
    settle(); adv();
    settle(); chk("ovsel.oob_A", 64'(a_oidx), 64'(2)); chk("ovsel.inrange_B", 64'(b_oidx), 64'(3)); adv();
    ovr_en = 1'b0;

    // Asynchronous reset in the middle of a burst.
    drv(2, SQ, 32'h604, 32'h0);
    settle(); adv();
    do_reset();

    m_hburst = '0;
    repeat (3000) begin rand_in(); settle(); adv(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
